index_vector_decoder: RTL and testbench

Sequential inverse of the 8-to-3 priority encoder. Accepts a framed stream of encoded indices over a valid/ready handshake, expands each one to its one-hot bit, and ORs the bits into a vector. On the last beat of a frame, it presents the rebuilt vector on a second valid/ready handshake. It sits on the receive side of any link that carries priority-encoded request indices, and rebuilds the request mask for downstream arbitration.

---
 rtl/index_vector_decoder_if.sv | 26 ++
 rtl/index_vector_decoder.sv | 112 +++++++++++
 tb/tb_index_vector_decoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/index_vector_decoder_if.sv
// Framed index stream in, rebuilt vector out: both valid/ready handshakes of index_vector_decoder.
// master drives the index beats and vec_ready; slave is the decoder itself.
interface index_vector_decoder_if #(
    parameter int unsigned IDX_W = 3
);
    logic [IDX_W-1:0]        idx;
    logic                    idx_null;
    logic                    idx_last;
    logic                    idx_valid;
    logic                    idx_ready;
    logic [(1<<IDX_W)-1:0]   vec;
    logic [IDX_W:0]          vec_cnt;
    logic                    dup_err;
    logic                    vec_valid;
    logic                    vec_ready;

    modport master (
        output idx, idx_null, idx_last, idx_valid, vec_ready,
        input  idx_ready, vec, vec_cnt, dup_err, vec_valid
    );

    modport slave (
        input  idx, idx_null, idx_last, idx_valid, vec_ready,
        output idx_ready, vec, vec_cnt, dup_err, vec_valid
    );
endinterface

// File: rtl/index_vector_decoder.sv
// Rebuilds a one-hot request mask from a framed stream of priority-encoded indices.
// Optional repeated-index reporting is compiled in with `define IDX_DUP_CHECK_EN.
module index_vector_decoder #(
    parameter int unsigned IDX_W = 3
) (
    input logic                   clk,
    input logic                   rst,
    index_vector_decoder_if.slave bus
);
    localparam int unsigned VecW = 1 << IDX_W;
    localparam int unsigned CntW = IDX_W + 1;

    typedef enum logic {
        StAccum,
        StHold
    } state_e;

    state_e          state_q;
    logic [VecW-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic [VecW-1:0] vec_q;
    logic [CntW-1:0] vec_cnt_q;
    logic            vec_valid_q;

    logic [VecW-1:0] bit_oh;
    logic [VecW-1:0] acc_nxt;
    logic [CntW-1:0] cnt_nxt;
    logic            accept;

    assign accept = bus.idx_valid && (state_q == StAccum);

    always_comb begin
        bit_oh = '0;
        if (!bus.idx_null) begin
            bit_oh[bus.idx] = 1'b1;
        end
    end

    assign acc_nxt = acc_q | bit_oh;
    // Count saturates at all-ones instead of wrapping.
    assign cnt_nxt = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            vec_q       <= '0;
            vec_cnt_q   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (bus.idx_last) begin
                            vec_q       <= acc_nxt;
                            vec_cnt_q   <= cnt_nxt;
                            vec_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= StHold;
                        end else begin
                            acc_q <= acc_nxt;
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                StHold: begin
                    if (bus.vec_ready) begin
                        vec_valid_q <= 1'b0;
                        state_q     <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

`ifdef IDX_DUP_CHECK_EN
    logic dup_q;
    logic dup_err_q;
    logic dup_nxt;

    // Sticky: any non-null beat landing on an already-set bit, including earlier in this frame.
    assign dup_nxt = dup_q | (|(acc_q & bit_oh));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_q     <= 1'b0;
            dup_err_q <= 1'b0;
        end else if (accept) begin
            if (bus.idx_last) begin
                dup_err_q <= dup_nxt;
                dup_q     <= 1'b0;
            end else begin
                dup_q <= dup_nxt;
            end
        end else if (state_q == StHold && bus.vec_ready) begin
            dup_err_q <= 1'b0;
        end
    end

    assign bus.dup_err = dup_err_q;
`else
    assign bus.dup_err = 1'b0;
`endif

    assign bus.idx_ready = (state_q == StAccum);
    assign bus.vec       = vec_q;
    assign bus.vec_cnt   = vec_cnt_q;
    assign bus.vec_valid = vec_valid_q;
endmodule

// File: tb/tb_index_vector_decoder.sv
// Scoreboard bench for index_vector_decoder; expected dup_err follows IDX_DUP_CHECK_EN.
module tb_index_vector_decoder;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    index_vector_decoder_if #(.IDX_W(3)) bus ();

    index_vector_decoder #(.IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] vec;
        logic [3:0] cnt;
        logic       dup;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc;
    logic [3:0] m_cnt;
    logic       m_dup;
    int         handshakes;

    task automatic model_clear();
        m_acc = '0;
        m_cnt = '0;
        m_dup = 1'b0;
    endtask

    // Scoreboard pops on every vector handshake.
    always @(negedge clk) begin
        if (!rst && bus.vec_valid && bus.vec_ready) begin
            handshakes++;
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL unexpected_vec: got vec=%h cnt=%0d, required none", bus.vec,
                         bus.vec_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.vec !== e.vec || bus.vec_cnt !== e.cnt || bus.dup_err !== e.dup) begin
                    failed++;
                    $display("FAIL vec_out: got vec=%h cnt=%0d dup=%b, required vec=%h cnt=%0d dup=%b",
                             bus.vec, bus.vec_cnt, bus.dup_err, e.vec, e.cnt, e.dup);
                end
            end
        end
    end

    task automatic send_beat(input logic [2:0] i, input logic nul, input logic last,
                             output int cycles);
        logic acc_now;
        cycles = 0;
        bus.idx       = i;
        bus.idx_null  = nul;
        bus.idx_last  = last;
        bus.idx_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc_now = bus.idx_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (acc_now) break;
            if (cycles > 50) begin
                tests++;
                failed++;
                $display("FAIL beat_timeout: got no accept in %0d cycles, required accept", cycles);
                bus.idx_valid = 1'b0;
                return;
            end
        end
        bus.idx_valid = 1'b0;
        if (!nul) begin
`ifdef IDX_DUP_CHECK_EN
            if (m_acc[i]) m_dup = 1'b1;
`endif
            m_acc[i] = 1'b1;
        end
        if (m_cnt != 4'hf) m_cnt = m_cnt + 4'd1;
        if (last) begin
            sb.push_back('{vec: m_acc, cnt: m_cnt, dup: m_dup});
            model_clear();
        end
    endtask

    task automatic send(input logic [2:0] i, input logic nul, input logic last);
        int c;
        send_beat(i, nul, last, c);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL %s_drain: got %0d pending vectors, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.idx = '0;
        bus.idx_null = 1'b0;
        bus.idx_last = 1'b0;
        bus.idx_valid = 1'b0;
        bus.vec_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests += 5;
        if (bus.vec_valid !== 1'b0) begin
            failed++; $display("FAIL rst_vec_valid: got %b, required 0", bus.vec_valid);
        end
        if (bus.idx_ready !== 1'b1) begin
            failed++; $display("FAIL rst_idx_ready: got %b, required 1", bus.idx_ready);
        end
        if (bus.vec !== 8'h00) begin
            failed++; $display("FAIL rst_vec: got %h, required 00", bus.vec);
        end
        if (bus.vec_cnt !== 4'd0) begin
            failed++; $display("FAIL rst_vec_cnt: got %0d, required 0", bus.vec_cnt);
        end
        if (bus.dup_err !== 1'b0) begin
            failed++; $display("FAIL rst_dup_err: got %b, required 0", bus.dup_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send(3'd5, 1'b0, 1'b0);
        send(3'd2, 1'b0, 1'b1);
        tests++;
        if (bus.vec_valid !== 1'b1) begin
            failed++; $display("FAIL basic_latency: got vec_valid=%b, required 1", bus.vec_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.vec_valid !== 1'b0) begin
            failed++; $display("FAIL basic_pulse: got vec_valid=%b, required 0", bus.vec_valid);
        end
        wait_drain("basic");
    endtask

    task automatic test_null();
        send(3'd6, 1'b1, 1'b1);
        wait_drain("null");
    endtask

    task automatic test_dup();
        send(3'd7, 1'b0, 1'b0);
        send(3'd7, 1'b0, 1'b0);
        send(3'd0, 1'b0, 1'b1);
        wait_drain("dup");
    endtask

    task automatic test_stall();
        int c;
        bus.vec_ready = 1'b0;
        send(3'd3, 1'b0, 1'b1);
        bus.idx = 3'd4;
        bus.idx_null = 1'b0;
        bus.idx_last = 1'b1;
        bus.idx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (bus.idx_ready !== 1'b0 || bus.vec !== 8'h08 || bus.vec_valid !== 1'b1) begin
                failed++;
                $display("FAIL stall_hold: got ready=%b vec=%h valid=%b, required 0 08 1",
                         bus.idx_ready, bus.vec, bus.vec_valid);
            end
        end
        @(posedge clk);
        #1;
        bus.vec_ready = 1'b1;
        send_beat(3'd4, 1'b0, 1'b1, c);
        tests++;
        if (c != 2) begin
            failed++; $display("FAIL stall_accept_cycles: got %0d, required 2", c);
        end
        wait_drain("stall");
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 20; k++) begin
            send(3'd1, 1'b0, (k == 19));
        end
        wait_drain("saturate");
    endtask

    task automatic test_reset_mid();
        int hs0;
        send(3'd6, 1'b0, 1'b0);
        send(3'd4, 1'b0, 1'b0);
        hs0 = handshakes;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.vec_valid !== 1'b0 || bus.idx_ready !== 1'b1) begin
            failed++;
            $display("FAIL midrst_state: got valid=%b ready=%b, required 0 1", bus.vec_valid,
                     bus.idx_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        send(3'd3, 1'b0, 1'b1);
        wait_drain("midrst");
        tests++;
        if (handshakes != hs0 + 1) begin
            failed++;
            $display("FAIL midrst_count: got %0d vectors, required 1", handshakes - hs0);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        handshakes = 0;
        test_reset();
        test_basic();
        test_null();
        test_dup();
        test_stall();
        test_saturate();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
